snake_body_reader: RTL and testbench
====================================

// Module: snake_body_reader
// PURPOSE
//  Read side of the snake body shift register: walks the packed X/Y body vectors
//  one segment at a time, head first. Streams each segment to a consumer (VGA
//  plotter, food-overlap check) over a valid/ready handshake.
//  Snapshots the body at start, so a body shift mid-scan cannot corrupt the scan.
//  Reports self-collision: any body segment with index >= 1 equal to the head.
// PARAMETERS
//  XW       8   bits per X coordinate
//  YW       7   bits per Y coordinate
//  MAX_LEN  16  segment slots in the body vectors
//  LEN_W    5   width of length/index; must satisfy 2**LEN_W > MAX_LEN
// PORTS
//  clk        in   1             system clock; single clock domain
//  resetn     in   1             asynchronous, active-low reset
//  start      in   1             begin a scan; sampled only in IDLE
//  length     in   LEN_W         live segment count; sampled with start
//  body_x     in   XW*MAX_LEN    packed X coords, segment 0 (head) in MS slice
//  body_y     in   YW*MAX_LEN    packed Y coords, same layout as body_x
//  seg_x      out  XW            X of current segment
//  seg_y      out  YW            Y of current segment
//  seg_idx    out  LEN_W         index of current segment (0 = head)
//  seg_valid  out  1             seg_* outputs hold a segment
//  seg_ready  in   1             consumer accepts the segment this cycle
//  busy       out  1             high in SCAN and DONE
//  done       out  1             one-cycle pulse at scan end
//  collide    out  1             self-collision result; valid while done=1, held until next start
// BEHAVIOUR
//  - Reset (async, resetn=0): state=IDLE. seg_x, seg_y, seg_idx, seg_valid, busy,
//    done and collide = 0. Snapshot registers are cleared. A scan in progress is
//    aborted and no done pulse is produced.
//  - Slicing: segment i occupies body_x[XW*(MAX_LEN-i)-1 -: XW]; body_y uses the same layout with YW.
//  - Length: len_eff = min(length, MAX_LEN).
//  - FSM IDLE:
//    * start=1 and len_eff>0 -> capture body_x, body_y and len_eff; clear collide; go to SCAN.
//    * start=1 and len_eff=0 -> clear collide; go to DONE; no segments are emitted.
//  - FSM SCAN:
//    * seg_valid=1; outputs are driven from the snapshot at idx.
//    * Latency: the first segment is presented the cycle after start is sampled.
//    * A segment transfers when seg_valid & seg_ready. On transfer: idx+1; at idx=len_eff-1, go to DONE.
//    * With seg_ready held high, one segment transfers per cycle.
//    * seg_* must stay stable while seg_valid=1 and seg_ready=0.
//  - FSM DONE: lasts exactly one cycle with done=1 and busy=1, then returns to IDLE.
//    Any start seen in SCAN or DONE is ignored (not queued).
//  - Collision: on each transfer with idx>=1, compare (x,y) against the snapshot head.
//    On a match, collide is set and stays set (sticky) for this scan. Segment 0 is never compared.
//  - body_x, body_y and length may change during a scan with no effect on it.
//  - seg_valid=0 outside SCAN; seg_x, seg_y and seg_idx then hold their last value.
// STRUCTURE
//  - snake_pkg holds the shared constants XW, YW, MAX_LEN, LEN_W and the state encoding
//    (IDLE=2'd0, SCAN=2'd1, DONE=2'd2). The shift-register writer uses the same package.
//  - Sub-module snake_seg_mux: combinational select of segment idx from the packed
//    snapshot. One instance for X (width XW), one for Y (width YW).
//  - Top level: FSM, index counter, snapshot registers and collision comparator.
// TESTING
//  1. length=3, head (10,5), body (9,5),(8,5), seg_ready=1 -> idx 0,1,2 on 3 consecutive cycles;
//     done on the 4th cycle; collide=0.
//  2. length=4, body (4,4),(5,4),(5,5),(4,4) -> collide=1 with the done pulse; all 4 segments emitted.
//  3. Back-pressure: seg_ready toggles 1,0,0,1 during scan -> seg_* stable while stalled;
//     no segment dropped or duplicated.
//  4. length=0 -> done the cycle after start; seg_valid never asserts.
//     length=20 (> MAX_LEN=16) -> exactly 16 segments emitted.
//  5. Body inputs rewritten mid-scan -> emitted values match the snapshot at start;
//     a start pulse during SCAN is ignored.
//  6. resetn low mid-scan at idx=2 -> all outputs 0 immediately (async); no done pulse;
//     a fresh start after reset scans from idx 0.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants and state encoding for the snake body shift register
// and its readers.
package snake_pkg;
    localparam int XW      = 8;
    localparam int YW      = 7;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Lengths beyond the number of body slots are clamped to the slot count.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    endfunction
endpackage

// File: rtl/snake_seg_mux.sv
// Combinational pick of one segment slice from a packed body vector;
// segment 0 lives in the most significant slice.
module snake_seg_mux #(
    parameter int W       = 8,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic [W*MAX_LEN-1:0] vec,
    input  logic [LEN_W-1:0]     sel,
    output logic [W-1:0]         seg
);
    always_comb begin
        seg = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (sel == LEN_W'(i))
                seg = vec[W*(MAX_LEN-i)-1 -: W];
        end
    end
endmodule

// File: rtl/snake_body_reader.sv
// Streams a snapshot of the snake body head-first over valid/ready and
// flags any later segment that lands on the head.
module snake_body_reader
    import snake_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [LEN_W-1:0]      length,
    input  logic [XW*MAX_LEN-1:0] body_x,
    input  logic [YW*MAX_LEN-1:0] body_y,
    output logic [XW-1:0]         seg_x,
    output logic [YW-1:0]         seg_y,
    output logic [LEN_W-1:0]      seg_idx,
    output logic                  seg_valid,
    input  logic                  seg_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  collide
);
    state_t                state, state_next;
    logic [LEN_W-1:0]      idx, len_q, len_eff;
    logic [XW*MAX_LEN-1:0] snap_x;
    logic [YW*MAX_LEN-1:0] snap_y;
    logic [XW-1:0]         cur_x, head_x;
    logic [YW-1:0]         cur_y, head_y;
    logic                  collide_q, xfer, last, hit;

    assign len_eff = clamp_len(length);
    assign xfer    = (state == SCAN) && seg_ready;
    assign last    = (idx == len_q - LEN_W'(1));
    assign head_x  = snap_x[XW*MAX_LEN-1 -: XW];
    assign head_y  = snap_y[YW*MAX_LEN-1 -: YW];
    assign hit     = (idx != '0) && (cur_x == head_x) && (cur_y == head_y);

    snake_seg_mux #(.W(XW), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_mux_x (
        .vec (snap_x),
        .sel (idx),
        .seg (cur_x)
    );

    snake_seg_mux #(.W(YW), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_mux_y (
        .vec (snap_y),
        .sel (idx),
        .seg (cur_y)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (len_eff != '0) ? SCAN : DONE;
            SCAN:    if (xfer && last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // idx parks on the last segment so seg_* keep their final value after the scan.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            snap_x    <= '0;
            snap_y    <= '0;
            len_q     <= '0;
            idx       <= '0;
            collide_q <= 1'b0;
        end else if (state == IDLE && start) begin
            collide_q <= 1'b0;
            if (len_eff != '0) begin
                snap_x <= body_x;
                snap_y <= body_y;
                len_q  <= len_eff;
                idx    <= '0;
            end
        end else if (xfer) begin
            if (hit)   collide_q <= 1'b1;
            if (!last) idx       <= idx + LEN_W'(1);
        end
    end

    assign seg_x     = cur_x;
    assign seg_y     = cur_y;
    assign seg_idx   = idx;
    assign seg_valid = (state == SCAN);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign collide   = collide_q;
endmodule

// File: tb/tb_snake_body_reader.sv
// Scoreboard bench: stimulus queues expected segments and collide results,
// a negedge monitor pops and compares whatever the reader emits.
module tb_snake_body_reader;
    import snake_pkg::*;

    logic                  clk, resetn, start, seg_ready;
    logic [LEN_W-1:0]      length;
    logic [XW*MAX_LEN-1:0] body_x;
    logic [YW*MAX_LEN-1:0] body_y;
    logic [XW-1:0]         seg_x;
    logic [YW-1:0]         seg_y;
    logic [LEN_W-1:0]      seg_idx;
    logic                  seg_valid, busy, done, collide;

    typedef struct {
        logic [XW-1:0]    x;
        logic [YW-1:0]    y;
        logic [LEN_W-1:0] idx;
    } seg_t;

    seg_t       sb_q[$];
    logic       coll_q[$];
    logic [XW-1:0] tx[MAX_LEN];
    logic [YW-1:0] ty[MAX_LEN];
    int checks = 0;
    int errors = 0;

    snake_body_reader dut (
        .clk(clk), .resetn(resetn), .start(start), .length(length),
        .body_x(body_x), .body_y(body_y), .seg_x(seg_x), .seg_y(seg_y),
        .seg_idx(seg_idx), .seg_valid(seg_valid), .seg_ready(seg_ready),
        .busy(busy), .done(done), .collide(collide)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: transfers against the segment queue, done pulses against the
    // collide queue, and seg_* stability across stalled cycles.
    logic          stalled = 1'b0;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [LEN_W-1:0] pi;
    always @(negedge clk) begin
        if (!resetn) begin
            stalled = 1'b0;
        end else begin
            if (stalled && seg_valid) begin
                chk("stall_stable", {seg_x, seg_y, seg_idx}, {px, py, pi});
            end
            if (seg_valid && seg_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_segment", 32'(seg_idx), 32'hFFFF);
                end else begin
                    seg_t e;
                    e = sb_q.pop_front();
                    chk("seg_x", 32'(seg_x), 32'(e.x));
                    chk("seg_y", 32'(seg_y), 32'(e.y));
                    chk("seg_idx", 32'(seg_idx), 32'(e.idx));
                end
            end
            stalled = seg_valid && !seg_ready;
            px = seg_x; py = seg_y; pi = seg_idx;
            if (done) begin
                if (coll_q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
                else                    chk("collide_at_done", 32'(collide), 32'(coll_q.pop_front()));
            end
        end
    end

    task automatic set_seg(input int i, input int x, input int y);
        tx[i] = XW'(x);
        ty[i] = YW'(y);
    endtask

    task automatic clear_body();
        for (int i = 0; i < MAX_LEN; i++) set_seg(i, 0, 0);
    endtask

    task automatic pack_body();
        for (int i = 0; i < MAX_LEN; i++) begin
            body_x[XW*(MAX_LEN-i)-1 -: XW] = tx[i];
            body_y[YW*(MAX_LEN-i)-1 -: YW] = ty[i];
        end
    endtask

    // One complete scan; pat bit k is seg_ready in scan cycle k.
    task automatic run(input string name, input int len, input logic [31:0] pat,
                       input int exp_cyc, input logic exp_coll, input bit disturb);
        int le, cyc, nx;
        bit seen;
        le = (len > MAX_LEN) ? MAX_LEN : len;
        cyc = 0; nx = 0; seen = 0;
        pack_body();
        for (int i = 0; i < le; i++) sb_q.push_back('{tx[i], ty[i], LEN_W'(i)});
        coll_q.push_back(exp_coll);
        @(posedge clk); #1 start = 1'b1; length = LEN_W'(len);
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            seg_ready = (k < 32) ? pat[k] : 1'b1;
            if (disturb && k == 1) begin
                body_x = ~body_x; body_y = ~body_y; length = LEN_W'(1); start = 1'b1;
            end
            if (disturb && k == 2) start = 1'b0;
            @(negedge clk);
            cyc++;
            if (seg_valid && seg_ready) nx++;
            if (done) seen = 1;
            @(posedge clk); #1;
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        chk({name, "_nseg"}, 32'(nx), 32'(le));
        @(negedge clk);
        chk({name, "_idle_after"}, 32'(busy), 32'd0);
        chk({name, "_collide_held"}, 32'(collide), 32'(exp_coll));
        seg_ready = 1'b1;
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; seg_ready = 1'b1; length = '0;
        body_x = '0; body_y = '0;
        clear_body();
        repeat (2) @(negedge clk);
        chk("reset_outputs", {seg_x, seg_y, seg_idx, seg_valid, busy, done, collide}, '0);
        @(posedge clk); #1 resetn = 1'b1;

        // Straight scan, no collision
        clear_body();
        set_seg(0, 10, 5); set_seg(1, 9, 5); set_seg(2, 8, 5);
        run("t1", 3, 32'hFFFF_FFFF, 4, 1'b0, 0);

        // Tail lands on head
        clear_body();
        set_seg(0, 4, 4); set_seg(1, 5, 4); set_seg(2, 5, 5); set_seg(3, 4, 4);
        run("t2", 4, 32'hFFFF_FFFF, 5, 1'b1, 0);

        // Empty body: done next cycle, collide cleared
        run("t4_len0", 0, 32'hFFFF_FFFF, 1, 1'b0, 0);

        // Back-pressure 1,0,0,1 then ready
        clear_body();
        set_seg(0, 1, 2); set_seg(1, 3, 4); set_seg(2, 5, 6); set_seg(3, 7, 8);
        run("t3", 4, 32'hFFFF_FFF9, 7, 1'b0, 0);

        // Oversized length clamps to all slots
        for (int i = 0; i < MAX_LEN; i++) set_seg(i, i + 20, i + 1);
        run("t4_len20", 20, 32'hFFFF_FFFF, 17, 1'b0, 0);

        // Inputs rewritten and start pulsed mid-scan
        clear_body();
        set_seg(0, 30, 40); set_seg(1, 31, 40); set_seg(2, 32, 40); set_seg(3, 30, 40);
        run("t5", 4, 32'hFFFF_FFFF, 5, 1'b1, 1);

        // Async reset at idx 2
        clear_body();
        for (int i = 0; i < 5; i++) set_seg(i, 50 + i, 60 + i);
        pack_body();
        for (int i = 0; i < 3; i++) sb_q.push_back('{tx[i], ty[i], LEN_W'(i)});
        @(posedge clk); #1 start = 1'b1; length = LEN_W'(5);
        @(posedge clk); #1 start = 1'b0; seg_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_idx_before_reset", 32'(seg_idx), 32'd2);
        #1 resetn = 1'b0;
        #1 chk("t6_async_clear", {seg_x, seg_y, seg_idx, seg_valid, busy, done, collide}, '0);
        repeat (2) begin
            @(negedge clk);
            chk("t6_no_done", 32'(done), 32'd0);
        end
        chk("t6_queue_drained", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        chk("t6_idle_after_reset", 32'(busy), 32'd0);

        clear_body();
        set_seg(0, 10, 5); set_seg(1, 9, 5); set_seg(2, 8, 5);
        run("t6_rescan", 3, 32'hFFFF_FFFF, 4, 1'b0, 0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("coll_empty", 32'(coll_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
